fp_unpack_norm: RTL and testbench
=================================

FP_UNPACK_NORM -- requirements
Module: fp_unpack_norm

Interface
REQ-001 Parameter EXP_W, default 11, is the biased exponent field width.
REQ-002 Parameter MAN_W, default 52, is the stored fraction field width.
REQ-003 Parameter SHIFT_STEP, default 8, is the maximum left-shift applied to a subnormal mantissa per cycle (1..MAN_W).
REQ-004 The parameters SHALL satisfy MAN_W < 2^EXP_W, so the minimum exponent fits the exponent output.
REQ-005 Bias SHALL equal 2^(EXP_W-1)-1.
REQ-006 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 Port in_valid, input, 1 bit: fp_in holds a valid operand.
REQ-009 Port in_ready, output, 1 bit: block can accept an operand this cycle.
REQ-010 Port fp_in, input, EXP_W+MAN_W+1 bits: packed operand {sign, exp, frac}.
REQ-011 Port out_valid, output, 1 bit: the result outputs are valid.
REQ-012 Port out_ready, input, 1 bit: the consumer accepts the result.
REQ-013 Port sign, output, 1 bit: the operand sign.
REQ-014 Port exponent, output, EXP_W+2 bits, signed: the unbiased exponent of the normalized mantissa.
REQ-015 Port mantissa, output, MAN_W+1 bits: the significand with an explicit leading bit.
REQ-016 Ports is_nan, is_snan, is_inf, is_zero and is_denormalized, outputs, 1 bit each: class flags of the original operand.

Function
REQ-017 States SHALL be IDLE, NORM and HOLD.
REQ-018 in_ready SHALL equal (state==IDLE) OR (state==HOLD AND out_ready), and SHALL be 0 while rst is high.
REQ-019 out_valid SHALL be 1 exactly when state==HOLD.
REQ-020 Acceptance occurs on a cycle with in_valid AND in_ready.
- The operand is captured.
- Class flags and sign are registered.
- Normal and special operands go to HOLD on the next cycle, giving latency 1.
- Subnormal operands go to NORM.
REQ-021 A normal operand (exp not all-0, not all-1) SHALL produce:
- exponent = exp - bias, sign-extended;
- mantissa = {1, frac}.
REQ-022 A zero operand (exp=0, frac=0) SHALL produce is_zero=1, exponent=0 and mantissa=0, and SHALL preserve the sign.
REQ-023 An infinity operand (exp all-1, frac=0) SHALL produce is_inf=1, exponent=0 and mantissa=0.
REQ-024 A NaN operand (exp all-1, frac≠0) SHALL produce:
- is_nan=1;
- is_snan = NOT frac[MAN_W-1];
- exponent=0;
- mantissa={0, frac}, with the payload preserved.
REQ-025 For a subnormal operand (exp=0, frac≠0), the working mantissa SHALL load {0, frac} and the working exponent SHALL load 1-bias.
REQ-026 In NORM, each cycle SHALL shift the mantissa left by s = min(SHIFT_STEP, remaining leading zeros) and subtract s from the exponent.
REQ-027 NORM SHALL go to HOLD on the cycle the shifted mantissa has bit MAN_W = 1.
REQ-028 Subnormal results:
- final exponent = 1 - bias - lz, where lz is the leading-zero count of {0, frac};
- mantissa MSB = 1;
- is_denormalized = 1;
- latency = 1 + ceil(lz/SHIFT_STEP) cycles from acceptance to out_valid.
REQ-029 HOLD with out_ready=0 SHALL keep all outputs stable.
REQ-030 HOLD with out_ready=1 and no new operand SHALL return to IDLE.
REQ-031 HOLD with out_ready=1 and in_valid=1 (back-to-back) SHALL accept the new operand in the same cycle, with no bubble for normal and special operands.
REQ-032 in_valid SHALL be ignored in NORM, where in_ready=0.
REQ-033 Exactly one class flag among is_nan, is_inf, is_zero and is_denormalized, or none for normal operands, SHALL be set per result.
REQ-034 Flags SHALL be registered outputs and SHALL be 0 when out_valid=0.

Reset
REQ-035 rst=1 at a rising edge SHALL force state to IDLE.
REQ-036 rst=1 at a rising edge SHALL clear all registered outputs, including sign, exponent, mantissa, flags and out_valid, to 0.
REQ-037 Reset asserted during NORM or HOLD SHALL abort the operation.
REQ-038 An operation aborted by reset SHALL produce no output.
REQ-039 in_ready SHALL be 1 on the first cycle after rst deasserts.

Verification (defaults EXP_W=11, MAN_W=52, SHIFT_STEP=8)
REQ-040 fp_in=0x3FF0000000000000 with out_ready=1 SHALL give, one cycle later, out_valid=1, exponent=0, mantissa=0x10000000000000 and no flags set.
REQ-041 fp_in=0x0000000000000001 SHALL give:
- out_valid on the 8th cycle after acceptance;
- exponent=-1074;
- mantissa=0x10000000000000;
- is_denormalized=1.
REQ-042 fp_in=0x7FF0000000000001 SHALL give is_nan=1, is_snan=1, mantissa=0x0000000000001 and exponent=0.
REQ-043 fp_in=0x8000000000000000 SHALL give sign=1, is_zero=1 and mantissa=0.
REQ-044 HOLD with out_ready=0 for 5 cycles SHALL keep the outputs stable and in_ready=0.
REQ-045 Releasing out_ready with in_valid=1 in that HOLD state SHALL accept the next operand on the same edge.
REQ-046 rst pulsed 3 cycles into normalizing 0x0000000000000001 SHALL give out_valid=0, all outputs 0 and in_ready=1 on the next cycle.

Source files
------------

// File: rtl/fp_unpack_norm_if.sv
// fp_unpack_norm_if: operand/result handshake bundle for the floating-point unpacker
interface fp_unpack_norm_if #(
    parameter int EXP_W = 11,
    parameter int MAN_W = 52
);
    logic                    in_valid;
    logic                    in_ready;
    logic [EXP_W+MAN_W:0]    fp_in;
    logic                    out_valid;
    logic                    out_ready;
    logic                    sign;
    logic signed [EXP_W+1:0] exponent;
    logic [MAN_W:0]          mantissa;
    logic                    is_nan;
    logic                    is_snan;
    logic                    is_inf;
    logic                    is_zero;
    logic                    is_denormalized;
    modport master (
        output in_valid, fp_in, out_ready,
        input  in_ready, out_valid, sign, exponent, mantissa,
               is_nan, is_snan, is_inf, is_zero, is_denormalized
    );
    modport slave (
        input  in_valid, fp_in, out_ready,
        output in_ready, out_valid, sign, exponent, mantissa,
               is_nan, is_snan, is_inf, is_zero, is_denormalized
    );
endinterface

// File: rtl/fp_unpack_norm.sv
// fp_unpack_norm: unpacks an IEEE-style operand and normalizes subnormals over several cycles
module fp_unpack_norm #(
    parameter int EXP_W      = 11,
    parameter int MAN_W      = 52,
    parameter int SHIFT_STEP = 8
) (
    input logic             clk,
    input logic             rst,
    fp_unpack_norm_if.slave io
);
    localparam int EW   = EXP_W + 2;
    localparam int LZW  = $clog2(MAN_W + 2);
    localparam int BIAS = 2 ** (EXP_W - 1) - 1;
    localparam logic [LZW-1:0] STEP = LZW'(SHIFT_STEP);
    typedef enum logic [1:0] {IDLE, NORM, HOLD} state_t;
    state_t                state_q, state_d;
    logic                  sign_q, sign_d;
    logic signed [EW-1:0]  exp_q, exp_d;
    logic [MAN_W:0]        man_q, man_d;
    logic [4:0]            flg_q, flg_d;
    logic [LZW-1:0]        lz, s;
    logic                  hit;
    logic [EXP_W-1:0]      e;
    logic [MAN_W-1:0]      f;
    logic                  accept;
    assign e         = io.fp_in[EXP_W+MAN_W-1:MAN_W];
    assign f         = io.fp_in[MAN_W-1:0];
    assign io.in_ready  = !rst && (state_q == IDLE || (state_q == HOLD && io.out_ready));
    assign accept       = io.in_valid && io.in_ready;
    assign io.out_valid = state_q == HOLD;
    assign io.sign      = sign_q;
    assign io.exponent  = exp_q;
    assign io.mantissa  = man_q;
    assign {io.is_nan, io.is_snan, io.is_inf, io.is_zero, io.is_denormalized} = flg_q;
    // Decode accepted operands, step subnormal normalization, and retire held results
    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        exp_d   = exp_q;
        man_d   = man_q;
        flg_d   = flg_q;
        lz      = '0;
        hit     = 1'b0;
        for (int i = MAN_W; i >= 0; i--) begin
            hit = hit | man_q[i];
            lz  = lz + LZW'(!hit);
        end
        s = (lz > STEP) ? STEP : lz;
        if (accept) begin
            sign_d  = io.fp_in[EXP_W+MAN_W];
            state_d = HOLD;
            flg_d   = '0;
            exp_d   = '0;
            man_d   = '0;
            if (&e) begin
                man_d = (f == '0) ? '0 : {1'b0, f};
                flg_d = (f == '0) ? 5'b00100 : {1'b1, ~f[MAN_W-1], 3'b000};
            end else if (e == '0) begin
                flg_d = (f == '0) ? 5'b00010 : 5'b00000;
                if (f != '0) begin
                    man_d   = {1'b0, f};
                    exp_d   = EW'(1 - BIAS);
                    state_d = NORM;
                end
            end else begin
                exp_d = EW'({1'b0, e}) - EW'(BIAS);
                man_d = {1'b1, f};
            end
        end else if (state_q == NORM) begin
            man_d = man_q << s;
            exp_d = exp_q - EW'(s);
            if (man_d[MAN_W]) begin
                state_d = HOLD;
                flg_d   = 5'b00001;
            end
        end else if (state_q == HOLD && io.out_ready) begin
            state_d = IDLE;
            flg_d   = '0;
        end
    end
    // State and result registers, all cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sign_q  <= 1'b0;
            exp_q   <= '0;
            man_q   <= '0;
            flg_q   <= '0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            exp_q   <= exp_d;
            man_q   <= man_d;
            flg_q   <= flg_d;
        end
    end
endmodule

// File: tb/tb_fp_unpack_norm.sv
// tb_fp_unpack_norm: random and directed checks of fp_unpack_norm against a latency-level model
module tb_fp_unpack_norm;
    typedef struct packed {
        logic        s;
        logic [12:0] e;
        logic [52:0] m;
        logic [4:0]  f;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    fp_unpack_norm_if #(.EXP_W(11), .MAN_W(52)) io();
    fp_unpack_norm #(.EXP_W(11), .MAN_W(52), .SHIFT_STEP(8)) dut (.clk(clk), .rst(rst), .io(io));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic res_t model(input logic [63:0] x);
        res_t r = '0;
        int ex = int'(x[62:52]);
        logic [51:0] fr = x[51:0];
        longint m;
        int e;
        r.s = x[63];
        if (ex == 2047) begin
            if (fr == 0) r.f = 5'b00100;
            else begin
                r.m = {1'b0, fr};
                r.f = {1'b1, ~fr[51], 3'b000};
            end
        end else if (ex == 0) begin
            if (fr == 0) r.f = 5'b00010;
            else begin
                m = longint'(fr);
                e = -1022;
                while (m < (64'sd1 <<< 52)) begin
                    m = m * 2;
                    e = e - 1;
                end
                r.m = 53'(m);
                r.e = 13'(e);
                r.f = 5'b00001;
            end
        end else begin
            r.e = 13'(ex - 1023);
            r.m = {1'b1, fr};
        end
        return r;
    endfunction

    function automatic int lat_of(input logic [63:0] x);
        longint m = longint'(x[51:0]);
        int lz = 1;
        if (x[62:52] != 0 || m == 0) return 1;
        while (m < (64'sd1 <<< 51)) begin
            m = m * 2;
            lz++;
        end
        return 1 + (lz + 7) / 8;
    endfunction

    function automatic logic [63:0] gen();
        logic s = 1'($urandom);
        logic [10:0] e = '0;
        logic [51:0] f = 52'({$urandom, $urandom});
        case ($urandom_range(0, 5))
            0, 1: e = 11'($urandom_range(1, 2046));
            2: f = '0;
            3: begin e = 11'h7FF; f = '0; end
            4: begin e = 11'h7FF; if (f == 0) f = 52'd1; end
            default: begin f = f >> $urandom_range(0, 51); if (f == 0) f = 52'd1; end
        endcase
        return {s, e, f};
    endfunction

    res_t m_res = '0;
    logic m_hold = 1'b0;
    int   m_wait = 0;
    logic m_cleared = 1'b1;
    logic started = 1'b0;

    // Reference model: tracks only when a result is due and what it must be
    always @(posedge clk) begin : mdl
        logic h, rdy, cl;
        int w;
        res_t r;
        h = m_hold; w = m_wait; r = m_res; cl = m_cleared;
        if (rst) begin
            h = 1'b0; w = 0; r = '0; cl = 1'b1;
        end else begin
            rdy = (w == 0 && !h) || (h && io.out_ready);
            if (w > 0) begin
                w = w - 1;
                if (w == 0) h = 1'b1;
            end else if (h && io.out_ready) h = 1'b0;
            if (rdy && io.in_valid) begin
                r  = model(io.fp_in);
                cl = 1'b0;
                w  = lat_of(io.fp_in) - 1;
                h  = (w == 0);
            end
        end
        m_hold <= h; m_wait <= w; m_res <= r; m_cleared <= cl; started <= 1'b1;
    end

    // Per-cycle comparison of DUT outputs with the model
    always @(negedge clk) if (started) begin
        chk("in_ready", {63'd0, io.in_ready},
            {63'd0, !rst && ((m_wait == 0 && !m_hold) || (m_hold && io.out_ready))});
        chk("out_valid", {63'd0, io.out_valid}, {63'd0, m_hold});
        if (m_hold || m_cleared) begin
            chk("sign", {63'd0, io.sign}, {63'd0, m_res.s});
            chk("exponent", io.exponent, $signed(m_res.e));
            chk("mantissa", {11'd0, io.mantissa}, {11'd0, m_res.m});
            chk("flags", {59'd0, io.is_nan, io.is_snan, io.is_inf, io.is_zero, io.is_denormalized},
                {59'd0, m_res.f});
        end else
            chk("flags_idle", {59'd0, io.is_nan, io.is_snan, io.is_inf, io.is_zero, io.is_denormalized}, 64'd0);
    end

    task automatic send(input logic [63:0] x);
        int k = 0;
        @(posedge clk); #1;
        io.in_valid = 1'b1;
        io.fp_in = x;
        @(negedge clk);
        while (!io.in_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k >= 100) chk("accept_timeout", 64'(k), 64'd0);
        @(posedge clk); #1;
        io.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int c);
        c = 1;
        @(negedge clk);
        while (!io.out_valid && c < 50) begin
            @(negedge clk);
            c++;
        end
    endtask

    initial begin
        res_t r;
        int c;
        io.in_valid = 1'b0;
        io.out_ready = 1'b1;
        io.fp_in = '0;
        r = model(64'h3FF0000000000000);
        chk("pin_model_one", {r.e, r.m, r.f}, {13'd0, 53'h10000000000000, 5'd0});
        r = model(64'h0000000000000001);
        chk("pin_model_min_exp", $signed(r.e), -64'sd1074);
        chk("pin_model_min_lat", 64'(lat_of(64'h1)), 64'd8);
        r = model(64'h7FF0000000000001);
        chk("pin_model_snan", {r.m, r.f}, {53'd1, 5'b11000});
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        send(64'h3FF0000000000000);
        @(negedge clk);
        chk("one_valid", {63'd0, io.out_valid}, 64'd1);
        chk("one_exp", io.exponent, 64'd0);
        chk("one_man", {11'd0, io.mantissa}, 64'h10000000000000);

        send(64'h0000000000000001);
        wait_valid(c);
        chk("den_latency", 64'(c), 64'd8);
        chk("den_exp", io.exponent, -64'sd1074);
        chk("den_man", {11'd0, io.mantissa}, 64'h10000000000000);
        chk("den_flag", {63'd0, io.is_denormalized}, 64'd1);

        send(64'h7FF0000000000001);
        @(negedge clk);
        chk("snan_flags", {62'd0, io.is_nan, io.is_snan}, 64'd3);
        chk("snan_man", {11'd0, io.mantissa}, 64'd1);

        send(64'h8000000000000000);
        @(negedge clk);
        chk("nzero", {61'd0, io.sign, io.is_zero, io.out_valid}, 64'd7);

        @(posedge clk); #1 io.out_ready = 1'b0;
        send(64'h4000000000000000);
        repeat (5) begin
            @(negedge clk);
            chk("hold_ready", {62'd0, io.in_ready, io.out_valid}, 64'd1);
        end
        @(posedge clk); #1;
        io.in_valid = 1'b1;
        io.fp_in = 64'hC008000000000000;
        io.out_ready = 1'b1;
        @(negedge clk);
        chk("b2b_ready", {63'd0, io.in_ready}, 64'd1);
        @(posedge clk); #1 io.in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_result", {io.out_valid, io.sign, io.exponent, io.mantissa}, {1'b1, 1'b1, 13'd1, 53'h18000000000000});

        send(64'h0000000000000001);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("abort", {io.in_ready, io.out_valid, io.sign, io.exponent, io.mantissa},
            {1'b1, 1'b0, 1'b0, 13'd0, 53'd0});

        repeat (3000) begin
            @(posedge clk); #1;
            io.in_valid = ($urandom % 4) != 0;
            io.fp_in = gen();
            io.out_ready = ($urandom % 10) < 7;
            if ($urandom % 500 == 0) rst = 1'b1;
            else rst = 1'b0;
        end
        @(posedge clk); #1;
        rst = 1'b0;
        io.in_valid = 1'b0;
        io.out_ready = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
